saes_cbc_chain: RTL and testbench



---
 rtl/saes_pkg.sv | 24 ++
 rtl/saes_cbc_chain_if.sv | 24 ++
 rtl/saes_out_fifo.sv | 45 ++++
 rtl/saes_cbc_chain.sv | 101 ++++++++++
 tb/tb_saes_cbc_chain.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/saes_pkg.sv
// Shared S-AES definitions: block type, CBC front-end FSM encoding and the nibble S-boxes
// used by the encryptor, decryptor and key expansion.
package saes_pkg;

    localparam int BLOCK_W = 16;

    typedef logic [BLOCK_W-1:0] block_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        CAPTURE = 1'b1
    } cbc_state_t;

    localparam logic [3:0] SBOX [16] = '{
        4'h9, 4'h4, 4'hA, 4'hB, 4'hD, 4'h1, 4'h8, 4'h5,
        4'h6, 4'h2, 4'h0, 4'h3, 4'hC, 4'hE, 4'hF, 4'h7
    };

    localparam logic [3:0] SBOX_INV [16] = '{
        4'hA, 4'h5, 4'h9, 4'hB, 4'h1, 4'h7, 4'h8, 4'hF,
        4'h6, 4'h0, 4'h2, 4'h3, 4'hC, 4'h4, 4'hD, 4'hE
    };

endpackage

// File: rtl/saes_cbc_chain_if.sv
// Plaintext-in / ciphertext-out stream bundle of the CBC front end.
interface saes_cbc_chain_if;
    import saes_pkg::*;

    logic   in_valid;
    logic   in_ready;
    block_t in_data;
    logic   in_last;
    logic   out_valid;
    logic   out_ready;
    block_t out_data;
    logic   out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

endinterface

// File: rtl/saes_out_fifo.sv
// Synchronous ciphertext FIFO; head is the oldest entry, storage clears on reset so an
// empty FIFO presents zero.
module saes_out_fifo #(
    parameter  int DEPTH = 4,
    parameter  int W     = 17,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [W-1:0]  din_i,
    input  logic          pop_i,
    output logic [W-1:0]  head_o,
    output logic [CW-1:0] count_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_q] <= din_i;
                wr_q        <= wr_q + 1'b1;
            end
            if (pop_i) rd_q <= rd_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = count_q;

endmodule

// File: rtl/saes_cbc_chain.sv
// CBC chaining front end for the combinational S-AES encryptor: XORs plaintext with the
// chain value, registers it to the encryptor, and queues the returned ciphertext.
module saes_cbc_chain
    import saes_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   key_load_i,
    input  block_t key_in_i,
    input  logic   iv_load_i,
    input  block_t iv_in_i,
    output logic   cfg_ready_o,
    saes_cbc_chain_if.slave bus,
    output block_t enc_pt_o,
    output block_t enc_key_o,
    input  block_t enc_ct_i
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    cbc_state_t      state_q, state_d;
    block_t          key_q, key_d, iv_q, iv_d, chain_q, chain_d, pt_q, pt_d;
    logic            last_q, last_d;
    logic [CW-1:0]   count;
    logic [BLOCK_W:0] head;
    logic            key_go, iv_go, in_hs, push, pop;

    assign cfg_ready_o  = (state_q == IDLE);
    assign key_go       = key_load_i && cfg_ready_o;
    assign iv_go        = iv_load_i && cfg_ready_o;
    // Space is checked only in IDLE, so the push one cycle later can never overflow.
    assign bus.in_ready = cfg_ready_o && (count < CW'(FIFO_DEPTH)) && !key_load_i && !iv_load_i;
    assign in_hs        = bus.in_valid && bus.in_ready;
    assign push         = (state_q == CAPTURE);
    assign pop          = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        iv_d    = iv_q;
        chain_d = chain_q;
        pt_d    = pt_q;
        last_d  = last_q;
        if (key_go) key_d = key_in_i;
        if (iv_go) begin
            iv_d    = iv_in_i;
            chain_d = iv_in_i;
        end
        case (state_q)
            IDLE: if (in_hs) begin
                pt_d    = bus.in_data ^ chain_q;
                last_d  = bus.in_last;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                chain_d = last_q ? iv_q : enc_ct_i;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            iv_q    <= '0;
            chain_q <= '0;
            pt_q    <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            iv_q    <= iv_d;
            chain_q <= chain_d;
            pt_q    <= pt_d;
            last_q  <= last_d;
        end
    end

    saes_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (BLOCK_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   ({enc_ct_i, last_q}),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

    assign bus.out_valid = (count != '0);
    assign bus.out_data  = head[BLOCK_W:1];
    assign bus.out_last  = head[0];
    assign enc_pt_o      = pt_q;
    assign enc_key_o     = key_q;

endmodule

// File: tb/tb_saes_cbc_chain.sv
// Bench for the CBC front end: an S-AES reference stands in for the encryptor and a
// block-level CBC model with a ciphertext queue predicts the output stream.
`timescale 1ns/1ps
module tb_saes_cbc_chain;
    import saes_pkg::*;

    localparam int DEPTH = 4;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    logic   key_load = 1'b0, iv_load = 1'b0, cfg_ready;
    block_t key_in = '0, iv_in = '0, enc_pt, enc_key, enc_ct;

    saes_cbc_chain_if bus();

    saes_cbc_chain #(.FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .key_load_i  (key_load),
        .key_in_i    (key_in),
        .iv_load_i   (iv_load),
        .iv_in_i     (iv_in),
        .cfg_ready_o (cfg_ready),
        .bus         (bus),
        .enc_pt_o    (enc_pt),
        .enc_key_o   (enc_key),
        .enc_ct_i    (enc_ct)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    block_t      m_key = '0, m_iv = '0, m_chain = '0, exp_pt = '0;
    logic [16:0] sbq [$];

    function automatic logic [3:0] sb(input logic [3:0] x);
        case (x)
            4'h0: return 4'h9;  4'h1: return 4'h4;  4'h2: return 4'hA;  4'h3: return 4'hB;
            4'h4: return 4'hD;  4'h5: return 4'h1;  4'h6: return 4'h8;  4'h7: return 4'h5;
            4'h8: return 4'h6;  4'h9: return 4'h2;  4'hA: return 4'h0;  4'hB: return 4'h3;
            4'hC: return 4'hC;  4'hD: return 4'hE;  4'hE: return 4'hF;  default: return 4'h7;
        endcase
    endfunction

    function automatic logic [3:0] x4(input logic [3:0] a);
        logic [3:0] t;
        t = {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
        return {t[2:0], 1'b0} ^ (t[3] ? 4'h3 : 4'h0);
    endfunction

    function automatic logic [7:0] g(input logic [7:0] w, input logic [7:0] rc);
        return {sb(w[3:0]), sb(w[7:4])} ^ rc;
    endfunction

    // SubNibbles + ShiftRows, optionally MixColumns; columns are (n0,n1) and (n2,n3).
    function automatic logic [15:0] rnd(input logic [15:0] s, input bit mix);
        logic [3:0] a, b, c, d;
        a = sb(s[15:12]); b = sb(s[3:0]); c = sb(s[7:4]); d = sb(s[11:8]);
        if (!mix) return {a, b, c, d};
        return {a ^ x4(b), x4(a) ^ b, c ^ x4(d), x4(c) ^ d};
    endfunction

    function automatic logic [15:0] ref_enc(input logic [15:0] p, input logic [15:0] k);
        logic [7:0] w2, w3, w4, w5;
        w2 = k[15:8] ^ g(k[7:0], 8'h80);
        w3 = w2 ^ k[7:0];
        w4 = w2 ^ g(w3, 8'h30);
        w5 = w4 ^ w3;
        return rnd(rnd(p ^ k, 1'b1) ^ {w2, w3}, 1'b0) ^ {w4, w5};
    endfunction

    assign enc_ct = ref_enc(enc_pt, enc_key);

    task automatic cfg(input bit kl, input block_t k, input bit il, input block_t v);
        @(negedge clk);
        key_load = kl; key_in = k; iv_load = il; iv_in = v;
        #1;
        if (cfg_ready) begin
            if (kl) m_key = k;
            if (il) begin m_iv = v; m_chain = v; end
        end
        @(posedge clk); #1;
        key_load = 1'b0; iv_load = 1'b0;
    endtask

    // Offer a block for up to max_cyc cycles; on acceptance the CBC model advances.
    task automatic try_send(input block_t pt, input bit last, input int max_cyc, output bit acc);
        logic [15:0] ct;
        acc = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = pt; bus.in_last = last;
        for (int i = 0; i < max_cyc; i++) begin
            #1;
            if (bus.in_ready) acc = 1'b1;
            @(posedge clk);
            if (acc) break;
            @(negedge clk);
        end
        #1;
        bus.in_valid = 1'b0;
        if (acc) begin
            exp_pt  = pt ^ m_chain;
            ct      = ref_enc(exp_pt, m_key);
            sbq.push_back({ct, last});
            m_chain = last ? m_iv : ct;
        end
    endtask

    task automatic pop_one(output logic [16:0] got, output bit ok);
        ok  = 1'b0;
        got = 'x;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin ok = 1'b1; got = {bus.out_data, bus.out_last}; end
        end
        if (ok) begin
            bus.out_ready = 1'b1;
            @(posedge clk); #1;
            bus.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        m_key = '0; m_iv = '0; m_chain = '0; sbq.delete();
        @(negedge clk);
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
        tests++; if (cfg_ready !== 1'b1) begin fails++; $display("FAIL reset_cfg_ready got=%b want=1", cfg_ready); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
        tests++; if ({bus.out_data, bus.out_last} !== 17'h0) begin fails++; $display("FAIL reset_out_data got=%h want=0", {bus.out_data, bus.out_last}); end
        tests++; if (enc_pt !== 16'h0) begin fails++; $display("FAIL reset_enc_pt got=%h want=0000", enc_pt); end
        tests++; if (enc_key !== 16'h0) begin fails++; $display("FAIL reset_enc_key got=%h want=0000", enc_key); end
    endtask

    task automatic test_vectors();
        bit acc, ok;
        logic [16:0] got;
        cfg(1'b1, 16'h4AF5, 1'b1, 16'h0000);
        try_send(16'hD728, 1'b1, 20, acc);
        tests++; if (!acc) begin fails++; $display("FAIL vec1_accept got=0 want=1"); end
        @(negedge clk);
        tests++; if (enc_pt !== 16'hD728) begin fails++; $display("FAIL vec1_enc_pt got=%h want=D728", enc_pt); end
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL vec1_early got=%b want=0", bus.out_valid); end
        @(negedge clk);
        tests++; if (!bus.out_valid || {bus.out_data, bus.out_last} !== {16'h24EC, 1'b1}) begin
            fails++; $display("FAIL vec1_ct got=%b/%h/%b want=1/24EC/1", bus.out_valid, bus.out_data, bus.out_last);
        end
        pop_one(got, ok);
        tests++; if (!ok || got !== sbq[0]) begin fails++; $display("FAIL vec1_model got=%h want=%h", got, sbq[0]); end
        void'(sbq.pop_front());

        cfg(1'b1, 16'hA73B, 1'b1, 16'h0000);
        try_send(16'h6F6B, 1'b1, 20, acc);
        tests++; if (!acc) begin fails++; $display("FAIL vec2_accept got=0 want=1"); end
        @(negedge clk);
        @(negedge clk);
        tests++; if (!bus.out_valid || bus.out_data !== 16'h0738) begin
            fails++; $display("FAIL vec2_ct got=%b/%h want=1/0738", bus.out_valid, bus.out_data);
        end
        pop_one(got, ok);
        sbq.delete();
    endtask

    task automatic test_chaining();
        bit acc, ok;
        logic [16:0] got;
        logic [16:0] want [4] = '{{16'h24EC, 1'b0}, {16'h24EC, 1'b0}, {16'h24EC, 1'b1}, {16'h24EC, 1'b0}};
        cfg(1'b1, 16'h4AF5, 1'b1, 16'h0000);
        try_send(16'hD728, 1'b0, 20, acc);
        @(negedge clk);
        tests++; if (!acc || enc_pt !== 16'hD728) begin fails++; $display("FAIL chain_pt0 got=%h want=D728", enc_pt); end
        try_send(16'hF3C4, 1'b0, 20, acc);
        @(negedge clk);
        tests++; if (!acc || enc_pt !== 16'hD728) begin fails++; $display("FAIL chain_pt1 got=%h want=D728", enc_pt); end
        // Reloading the IV mid-message aborts the running chain.
        cfg(1'b0, 16'h0000, 1'b1, 16'h1234);
        try_send(16'hC51C, 1'b1, 20, acc);
        @(negedge clk);
        tests++; if (!acc || enc_pt !== 16'hD728) begin fails++; $display("FAIL chain_iv_pt got=%h want=D728", enc_pt); end
        try_send(16'hC51C, 1'b0, 20, acc);
        @(negedge clk);
        tests++; if (!acc || enc_pt !== 16'hD728) begin fails++; $display("FAIL chain_restart_pt got=%h want=D728", enc_pt); end
        for (int i = 0; i < 4; i++) begin
            pop_one(got, ok);
            tests++;
            if (!ok || got !== want[i] || sbq.size() == 0 || got !== sbq[0]) begin
                fails++; $display("FAIL chain_out%0d got=%h want=%h", i, got, want[i]);
            end
            if (sbq.size() != 0) void'(sbq.pop_front());
        end
    endtask

    task automatic test_random();
        bit acc, ok, last;
        block_t pt;
        logic [16:0] got;
        int keep;
        cfg(1'b1, block_t'($urandom), 1'b1, block_t'($urandom));
        for (int n = 0; n < 24; n++) begin
            if ($urandom_range(0, 7) == 0) cfg(1'b0, '0, 1'b1, block_t'($urandom));
            pt   = block_t'($urandom);
            last = ($urandom_range(0, 3) == 0);
            try_send(pt, last, 20, acc);
            tests++; if (!acc) begin fails++; $display("FAIL rand_accept n=%0d got=0 want=1", n); end
            @(negedge clk);
            tests++; if (enc_pt !== exp_pt) begin fails++; $display("FAIL rand_enc_pt n=%0d got=%h want=%h", n, enc_pt, exp_pt); end
            keep = (n == 23) ? 0 : ((sbq.size() >= DEPTH) ? 0 : int'($urandom_range(0, DEPTH)));
            while (sbq.size() > keep) begin
                pop_one(got, ok);
                tests++; if (!ok || got !== sbq[0]) begin fails++; $display("FAIL rand_out got=%h want=%h", got, sbq[0]); end
                void'(sbq.pop_front());
            end
        end
    endtask

    task automatic test_back_to_back();
        bit acc, ok;
        logic [16:0] got, head0;
        block_t pts [6];
        cfg(1'b1, block_t'($urandom), 1'b1, block_t'($urandom));
        for (int i = 0; i < 6; i++) pts[i] = block_t'($urandom);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            try_send(pts[i], 1'b0, 20, acc);
            tests++; if (!acc) begin fails++; $display("FAIL bp_fill%0d got=0 want=1", i); end
        end
        @(negedge clk);
        head0 = {bus.out_data, bus.out_last};
        try_send(pts[4], 1'b0, 6, acc);
        tests++; if (acc) begin fails++; $display("FAIL bp_full_accept got=1 want=0"); end
        got = {bus.out_data, bus.out_last};
        tests++; if (got !== head0 || got !== sbq[0]) begin fails++; $display("FAIL bp_head_stable got=%h want=%h", got, sbq[0]); end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        void'(sbq.pop_front());
        @(negedge clk);
        tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready_after_pop got=%b want=1", bus.in_ready); end
        try_send(pts[4], 1'b0, 1, acc);
        tests++; if (!acc) begin fails++; $display("FAIL bp_one_more got=0 want=1"); end
        try_send(pts[5], 1'b0, 6, acc);
        tests++; if (acc) begin fails++; $display("FAIL bp_second_more got=1 want=0"); end
        while (sbq.size() > 0) begin
            pop_one(got, ok);
            tests++; if (!ok || got !== sbq[0]) begin fails++; $display("FAIL bp_order got=%h want=%h", got, sbq[0]); end
            void'(sbq.pop_front());
        end
        try_send(pts[5], 1'b0, 20, acc);
        pop_one(got, ok);
        tests++; if (!acc || !ok || sbq.size() == 0 || got !== sbq[0]) begin fails++; $display("FAIL bp_last got=%h", got); end
        sbq.delete();
    endtask

    task automatic test_rst_priority();
        bit acc, ok;
        block_t k;
        logic [16:0] got;
        try_send(block_t'($urandom), 1'b0, 20, acc);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        m_key = '0; m_iv = '0; m_chain = '0; sbq.delete();
        @(negedge clk);
        tests++; if (!acc || bus.out_valid !== 1'b0 || enc_pt !== 16'h0 || enc_key !== 16'h0) begin
            fails++; $display("FAIL rst_capture got=%b/%h/%h want=0/0000/0000", bus.out_valid, enc_pt, enc_key);
        end
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rst_no_push got=%b want=0", bus.out_valid); end

        k = block_t'($urandom);
        @(negedge clk);
        key_load = 1'b1; key_in = k; bus.in_valid = 1'b1; bus.in_data = block_t'($urandom); bus.in_last = 1'b0;
        #1;
        tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL load_blocks_in got=%b want=0", bus.in_ready); end
        @(posedge clk); #1;
        key_load = 1'b0; bus.in_valid = 1'b0;
        m_key = k;
        @(negedge clk);
        tests++; if (enc_key !== k) begin fails++; $display("FAIL load_key got=%h want=%h", enc_key, k); end
        @(negedge clk);
        tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL load_no_block got=%b want=0", bus.out_valid); end

        try_send(block_t'($urandom), 1'b1, 20, acc);
        key_load = 1'b1; key_in = ~k;
        #1;
        tests++; if (cfg_ready !== 1'b0) begin fails++; $display("FAIL capture_cfg_ready got=%b want=0", cfg_ready); end
        @(posedge clk); #1;
        key_load = 1'b0;
        @(negedge clk);
        tests++; if (enc_key !== k) begin fails++; $display("FAIL capture_key_ignored got=%h want=%h", enc_key, k); end
        pop_one(got, ok);
        tests++; if (!acc || !ok || sbq.size() == 0 || got !== sbq[0]) begin fails++; $display("FAIL capture_block got=%h", got); end
        sbq.delete();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_vectors();
        test_chaining();
        test_random();
        test_back_to_back();
        test_rst_priority();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired after %0d tests", tests);
        $fatal(1, "watchdog");
    end

endmodule
